// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues single-outstanding imem requests and buffers
// returned words with their PC for decode. Define FETCH_PERF_EN to add perf counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
`endif
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]    r_state, w_state_nxt;
    logic [31:0]   r_pc, r_drop_addr;
    logic [PW-1:0] r_wr, r_rd;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [31:0]   r_hold_pc, r_hold_ins;
    logic [31:0]   r_mem_pc  [FIFO_DEPTH];
    logic [31:0]   r_mem_ins [FIFO_DEPTH];
    logic          w_push, w_pop, w_room, w_valid;

    // Redirect overrides both push and pop; the FIFO is simply cleared.
    assign w_valid   = (r_cnt != '0);
    assign w_push    = (r_state == ST_REQ) && imem_ack && !redirect;
    assign w_pop     = w_valid && !stall && !redirect;
    assign w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);
    assign w_room    = (w_cnt_nxt < CW'(FIFO_DEPTH));

    always_comb begin
        w_state_nxt = r_state;
        if (redirect) begin
            if (r_state == ST_DROP)
                w_state_nxt = imem_ack ? ST_REQ : ST_DROP;
            else if (r_state == ST_REQ && !imem_ack)
                w_state_nxt = ST_DROP;
            else
                w_state_nxt = ST_REQ;
        end else begin
            case (r_state)
                ST_IDLE: if (w_room) w_state_nxt = ST_REQ;
                ST_REQ:  if (imem_ack && !w_room) w_state_nxt = ST_IDLE;
                ST_DROP: if (imem_ack) w_state_nxt = ST_REQ;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pc        <= RESET_PC & ~32'h3;
            r_drop_addr <= RESET_PC & ~32'h3;
            r_wr        <= '0;
            r_rd        <= '0;
            r_cnt       <= '0;
            r_hold_pc   <= '0;
            r_hold_ins  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (redirect) begin
                r_pc  <= redirect_pc & ~32'h3;
                r_wr  <= '0;
                r_rd  <= '0;
                r_cnt <= '0;
                // The outstanding address must stay on the bus until its ack arrives.
                if (r_state == ST_REQ && !imem_ack)
                    r_drop_addr <= r_pc;
            end else begin
                if (w_push) begin
                    r_pc <= r_pc + 32'd4;
                    r_wr <= r_wr + PW'(1);
                end
                if (w_pop)
                    r_rd <= r_rd + PW'(1);
                r_cnt <= w_cnt_nxt;
            end
            if (w_valid) begin
                r_hold_pc  <= r_mem_pc[r_rd];
                r_hold_ins <= r_mem_ins[r_rd];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr]  <= r_pc;
            r_mem_ins[r_wr] <= imem_rdata;
        end
    end

    assign imem_req    = (r_state != ST_IDLE);
    assign imem_addr   = (r_state == ST_DROP) ? r_drop_addr : r_pc;
    assign instr_valid = w_valid;
    // When empty the last head is held rather than exposing stale FIFO slots.
    assign instruction = w_valid ? r_mem_ins[r_rd] : r_hold_ins;
    assign instr_pc    = w_valid ? r_mem_pc[r_rd]  : r_hold_pc;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched, r_perf_flushed;
    logic        w_discard;

    assign w_discard = imem_ack && ((r_state == ST_DROP) || (r_state == ST_REQ && redirect));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetched <= '0;
            r_perf_flushed <= '0;
        end else begin
            if (w_push)
                r_perf_fetched <= r_perf_fetched + 32'd1;
            r_perf_flushed <= r_perf_flushed + (redirect ? 32'(r_cnt) : 32'd0) + 32'(w_discard);
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_flushed = r_perf_flushed;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural imem responder plus a decode-side monitor.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_flushed;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int ws     = 0;
    int wcnt   = 0;
    bit auto_ack = 1'b1;

    typedef struct packed { logic [31:0] pc; logic [31:0] ins; } ent_t;
    ent_t got[$];

    fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .instr_valid(instr_valid), .instruction(instruction), .instr_pc(instr_pc)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory with ws wait states: acks on the (ws+1)th cycle of each request.
    always @(posedge clk) begin
        #1;
        if (auto_ack) begin
            if (imem_req && !rst) begin
                if (wcnt >= ws) begin
                    imem_ack   = 1'b1;
                    imem_rdata = f_word(imem_addr);
                    wcnt       = 0;
                end else begin
                    imem_ack = 1'b0;
                    wcnt     = wcnt + 1;
                end
            end else begin
                imem_ack = 1'b0;
                wcnt     = 0;
            end
        end else begin
            wcnt = 0;
        end
    end

    always @(negedge clk)
        if (!rst && instr_valid && !stall && !redirect)
            got.push_back({instr_pc, instruction});

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        got.delete();
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (imem_req) break;
            @(negedge clk);
        end
        if (!imem_req) check({tag, "_req_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic chk_got(input string tag, input int idx, input logic [31:0] pc);
        if (idx < got.size()) begin
            check($sformatf("%s_pc%0d", tag, idx), got[idx].pc, pc);
            check($sformatf("%s_ins%0d", tag, idx), got[idx].ins, f_word(pc));
        end else begin
            check($sformatf("%s_missing%0d", tag, idx), 32'(got.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        // reset values
        #2;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_ins", instruction, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
`ifdef FETCH_PERF_EN
        check("rst_perf_fetched", perf_fetched, 32'h0);
        check("rst_perf_flushed", perf_flushed, 32'h0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // zero-wait streaming
        wait_req("t1");
        check("t1_addr0", imem_addr, 32'h0);
        check("t1_valid0", 32'(instr_valid), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("t1_addr%0d", k), imem_addr, 32'(4 * k));
            check($sformatf("t1_req%0d", k), 32'(imem_req), 32'd1);
            check($sformatf("t1_valid%0d", k), 32'(instr_valid), 32'd1);
            check($sformatf("t1_ipc%0d", k), instr_pc, 32'(4 * (k - 1)));
            check($sformatf("t1_ins%0d", k), instruction, f_word(32'(4 * (k - 1))));
        end

        // three wait states
        ws = 3;
        do_reset();
        wait_req("t2");
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t2_addr%0d", k), imem_addr, 32'((k / 4) * 4));
            if (k == 4) begin
                check("t2_valid4", 32'(instr_valid), 32'd1);
                check("t2_ipc4", instr_pc, 32'h0);
            end
            if (k == 5) check("t2_valid5", 32'(instr_valid), 32'd0);
            @(negedge clk);
        end
        repeat (8) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_got("t2", i, 32'(4 * i));

        // stall fills the buffer and stops fetching
        ws = 0;
        stall = 1'b1;
        do_reset();
        repeat (10) @(negedge clk);
        check("t3_req_full", 32'(imem_req), 32'd0);
        check("t3_valid", 32'(instr_valid), 32'd1);
        check("t3_head_pc", instr_pc, 32'h0);
        check("t3_head_ins", instruction, f_word(32'h0));
        @(posedge clk);
        #1;
        stall = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 4; i++) chk_got("t3", i, 32'(4 * i));

        // redirect while a request is waiting for its ack
        auto_ack = 1'b0;
        imem_ack = 1'b0;
        do_reset();
        cyc();
        check("t4_addr0", imem_addr, 32'h0);
        imem_ack = 1'b1; imem_rdata = f_word(imem_addr);
        cyc();
        imem_rdata = f_word(imem_addr);
        cyc();
        check("t4_addr8", imem_addr, 32'h8);
        imem_ack = 1'b0;
        cyc();
        redirect = 1'b1; redirect_pc = 32'h100;
        cyc();
        redirect = 1'b0;
        @(negedge clk);
        check("t4_drop_req", 32'(imem_req), 32'd1);
        check("t4_drop_addr", imem_addr, 32'h8);
        cyc();
        check("t4_drop_addr2", imem_addr, 32'h8);
        imem_ack = 1'b1; imem_rdata = f_word(imem_addr);
        @(posedge clk);
        auto_ack = 1'b1;
        #1;
        check("t4_new_addr", imem_addr, 32'h100);
        check("t4_new_req", 32'(imem_req), 32'd1);
        repeat (6) @(negedge clk);
        chk_got("t4", 0, 32'h0);
        chk_got("t4", 1, 32'h4);
        chk_got("t4", 2, 32'h100);
        chk_got("t4", 3, 32'h104);

        // redirect coinciding with an ack and a pop
        auto_ack = 1'b0;
        imem_ack = 1'b0;
        do_reset();
        cyc();
        imem_ack = 1'b1; imem_rdata = f_word(imem_addr);
        cyc();
        check("t5_valid_pre", 32'(instr_valid), 32'd1);
        check("t5_addr_pre", imem_addr, 32'h4);
        imem_rdata = f_word(imem_addr);
        redirect = 1'b1; redirect_pc = 32'h203;
        @(posedge clk);
        auto_ack = 1'b1;
        #1;
        redirect = 1'b0;
        check("t5_flushed", 32'(instr_valid), 32'd0);
        check("t5_addr", imem_addr, 32'h200);
        check("t5_req", 32'(imem_req), 32'd1);
        repeat (4) @(negedge clk);
        chk_got("t5", 0, 32'h200);
        chk_got("t5", 1, 32'h204);

        // asynchronous reset mid-request
        do_reset();
        repeat (6) @(negedge clk);
        check("t6_busy", 32'(imem_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_req", 32'(imem_req), 32'd0);
        check("t6_valid", 32'(instr_valid), 32'd0);
        check("t6_addr", imem_addr, 32'h0);
        check("t6_ins", instruction, 32'h0);
        check("t6_ipc", instr_pc, 32'h0);
`ifdef FETCH_PERF_EN
        check("t6_perf_fetched", perf_fetched, 32'h0);
        check("t6_perf_flushed", perf_flushed, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;
        got.delete();
        wait_req("t6");
        check("t6_refetch", imem_addr, 32'h0);
        repeat (4) @(negedge clk);
        chk_got("t6", 0, 32'h0);
        chk_got("t6", 1, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the decode stage. It owns the PC and issues single-outstanding word requests to instruction memory over a req/ack handshake. Returned words are buffered with their PC in a small FIFO and presented to decode as a valid/stall stream. It handles branch/jump redirects from execute, including discarding a stale in-flight response.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset
FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
imem_req  output  1  fetch request, held until acked
imem_addr  output  32  word address of request, bits[1:0] always 00
imem_ack  input  1  response strobe, rdata valid this cycle
imem_rdata  input  32  fetched instruction word
redirect  input  1  one-cycle pulse: flush and restart at redirect_pc
redirect_pc  input  32  new fetch PC, bits[1:0] ignored (forced 00)
stall  input  1  decode cannot accept this cycle
instr_valid  output  1  FIFO head valid
instruction  output  32  FIFO head instruction word
instr_pc  output  32  PC of FIFO head

Behaviour:
- One clock; reset is asynchronous and active-high. On rst: pc=RESET_PC, FIFO empty (instr_valid=0), instruction=0, instr_pc=0, imem_req=0, imem_addr=RESET_PC, state IDLE.
- States: IDLE (no request), REQ (imem_req=1), DROP (imem_req=1, response will be discarded).
- IDLE -> REQ when next-cycle FIFO count < FIFO_DEPTH. The first cycle after reset release asserts imem_req with imem_addr=RESET_PC.
- REQ: imem_addr=pc, held stable until imem_ack. Ack is legal in the first cycle req is high (zero-wait memory).
- On an ack in REQ: push {pc, imem_rdata}; pc+=4 (wraps mod 2^32). Stay in REQ with the new address if post-push/pop count < FIFO_DEPTH, else go to IDLE.
- Throughput: with zero-wait memory and no stall, one instruction per cycle. Latency from ack to instr_valid is 1 cycle.
- Pop: on a cycle where instr_valid=1 and stall=0, the head is consumed. Push and pop may occur in the same cycle, and count is then unchanged.
- Full: at count==FIFO_DEPTH, no new request is issued. A push is never lost, because a request is only issued when a slot is reserved.
- Empty: instr_valid=0. instruction and instr_pc hold their last value, which decode must ignore.
- Redirect (highest priority, beats push, pop and stall):
  - FIFO flushed next cycle (instr_valid=0); pc=redirect_pc & ~3.
  - If no request is outstanding, or the ack arrives in the redirect cycle: that response is discarded, and state goes to REQ at the new pc.
  - If a request is outstanding with no ack this cycle: go to DROP. imem_req and the old imem_addr are held until ack, the response is discarded, then go to REQ at the new pc.
  - A redirect while in DROP updates pc only; the state stays DROP.
- Stall has no effect on fetch except through FIFO occupancy.
- Reset asserted mid-transaction: the outstanding request is abandoned, imem_req drops asynchronously, and the memory side must tolerate this.

Optional Feature:
FETCH_PERF_EN:
- Defined: adds outputs perf_fetched (32-bit, +1 per accepted ack not discarded) and perf_flushed (32-bit, +1 per FIFO entry plus discarded response lost to redirect). Both counters reset to 0 on rst and wrap at 2^32.
- Undefined: neither port nor counter logic exists, and behaviour is otherwise identical.

Test Plan:
- Reset release, zero-wait memory ack every req cycle, no stall -> imem_addr 0,4,8,12 on consecutive cycles; instr_valid from cycle 2; instr_pc 0,4,8 one per cycle.
- Memory with 3 wait states -> imem_addr held stable for 4 cycles per request; an instruction appears every 4 cycles; no duplicates.
- stall held high for 10 cycles, zero-wait memory -> after 2 pushes imem_req drops; head stays pc 0x0. After release, order 0x0,0x4,0x8 with no loss.
- redirect to 0x100 while a request to 0x8 waits for ack (ack 2 cycles later) -> state DROP, addr 0x8 held, its data never appears; next request is 0x100; first instr_pc=0x100.
- redirect to 0x203 in the same cycle as an ack and a pop -> FIFO empty next cycle, acked word dropped, next imem_addr=0x200.
- rst asserted mid-request for 1 cycle, asynchronously -> outputs return to reset values immediately; refetch starts at RESET_PC. With FETCH_PERF_EN, the counters read 0.
